// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - boot handshake and multi-cycle IF..WB state sequencer
//
// Runs the host boot handshake (send 0x99, take the program size, take the
// program image, send 0xAA), then loops the multi-cycle core through
// IF -> IF_ID -> ID -> ID_EX -> EX -> EX_MEM -> MEM -> MEM_WB -> WB -> WB_IF.
// EX dwells while ex_busy; MEM dwells for at least MEM_LATENCY cycles and
// while mem_busy. A halt seen in WB_IF parks the core in HALT until reset.
//
// Ports:
//   clk, reset                       core clock, synchronous active-high reset
//   stall                            freeze state and counters, gate strobes
//   size_fetch_done, prog_fetch_done boot progress from the host link
//   ex_busy, mem_busy                dwell requests for EX and MEM
//   halt                             halt request, honoured in WB_IF
//   tx_0x99, size_wren, prog_wren,
//   tx_0xAA                          boot strobes
//   core_reset                       pipeline-register reset (boot + INIT)
//   *_wren, ram_wren, reg_wren       pipeline, data RAM and register strobes
//   state, halted, instr_count       status
module stage_sequencer #(
  parameter bit BOOT_EN     = 1'b1,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             size_fetch_done,
  input  logic             prog_fetch_done,
  input  logic             ex_busy,
  input  logic             mem_busy,
  input  logic             halt,
  output logic             tx_0x99,
  output logic             size_wren,
  output logic             prog_wren,
  output logic             tx_0xAA,
  output logic             core_reset,
  output logic             wb_if_wren,
  output logic             if_id_wren,
  output logic             id_ex_wren,
  output logic             ex_mem_wren,
  output logic             mem_wb_wren,
  output logic             ram_wren,
  output logic             reg_wren,
  output logic [4:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // The MEM counter saturates one past the exit threshold so a long
  // mem_busy wait can never wrap it back to zero and re-fire ram_wren.
  localparam int            MW       = $clog2(MEM_LATENCY + 1);
  localparam logic [MW-1:0] MEM_LAST = MW'(MEM_LATENCY - 1);
  localparam logic [MW-1:0] MEM_SAT  = MW'(MEM_LATENCY);

  typedef enum logic [4:0] {
    S_TX99   = 5'd0,
    S_SIZE   = 5'd1,
    S_PROG   = 5'd2,
    S_TXAA   = 5'd3,
    S_INIT   = 5'd4,
    S_IF     = 5'd5,
    S_IF_ID  = 5'd6,
    S_ID     = 5'd7,
    S_ID_EX  = 5'd8,
    S_EX     = 5'd9,
    S_EX_MEM = 5'd10,
    S_MEM    = 5'd11,
    S_MEM_WB = 5'd12,
    S_WB     = 5'd13,
    S_WB_IF  = 5'd14,
    S_HALT   = 5'd15
  } state_t;

  state_t        st;
  logic [MW-1:0] mem_cnt;
  logic          go;

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= BOOT_EN ? S_TX99 : S_INIT;
      mem_cnt     <= '0;
      instr_count <= '0;
    end else if (!stall) begin
      case (st)
        S_TX99:   st <= S_SIZE;
        S_SIZE:   if (size_fetch_done) st <= S_PROG;
        S_PROG:   if (prog_fetch_done) st <= S_TXAA;
        S_TXAA:   st <= S_INIT;
        S_INIT:   st <= S_IF;
        S_IF:     st <= S_IF_ID;
        S_IF_ID:  st <= S_ID;
        S_ID:     st <= S_ID_EX;
        S_ID_EX:  st <= S_EX;
        S_EX:     if (!ex_busy) st <= S_EX_MEM;
        S_EX_MEM: begin
          st      <= S_MEM;
          mem_cnt <= '0;
        end
        S_MEM: begin
          if ((mem_cnt >= MEM_LAST) && !mem_busy) st <= S_MEM_WB;
          if (mem_cnt != MEM_SAT) mem_cnt <= mem_cnt + MW'(1);
        end
        S_MEM_WB: st <= S_WB;
        S_WB:     st <= S_WB_IF;
        S_WB_IF: begin
          instr_count <= instr_count + CNT_W'(1);
          st          <= halt ? S_HALT : S_IF;
        end
        S_HALT:   st <= S_HALT;
        default:  st <= S_INIT;
      endcase
    end
  end

  assign go          = ~stall;
  assign state       = st;
  assign halted      = (st == S_HALT);
  assign core_reset  = (st == S_TX99) | (st == S_SIZE) | (st == S_PROG) |
                       (st == S_TXAA) | (st == S_INIT);
  assign tx_0x99     = go & (st == S_TX99);
  assign size_wren   = go & (st == S_SIZE);
  assign prog_wren   = go & (st == S_PROG);
  assign tx_0xAA     = go & (st == S_TXAA);
  assign if_id_wren  = go & (st == S_IF_ID);
  assign id_ex_wren  = go & (st == S_ID_EX);
  assign ex_mem_wren = go & (st == S_EX_MEM);
  assign mem_wb_wren = go & (st == S_MEM_WB);
  assign reg_wren    = go & (st == S_WB);
  assign wb_if_wren  = go & (st == S_WB_IF);
  // Only the first counted MEM cycle writes the data RAM.
  assign ram_wren    = go & (st == S_MEM) & (mem_cnt == '0);

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - self-checking bench for stage_sequencer
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: BOOT_EN=1, MEM_LATENCY=3, CNT_W=4 ; index 1: BOOT_EN=0, MEM_LATENCY=1, CNT_W=32
  logic rst [2], stl [2], sfd [2], pfd [2], exb [2], memb [2], hlt [2];
  logic tx99 [2], szw [2], pgw [2], txaa [2], crst [2], wbif [2], ifid [2];
  logic idex [2], exmem [2], memwb [2], ram [2], regw [2], hltd [2];
  logic [4:0]  st [2];
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  stage_sequencer #(.BOOT_EN(1'b1), .MEM_LATENCY(3), .CNT_W(4)) dut_a (
    .clk(clk), .reset(rst[0]), .stall(stl[0]), .size_fetch_done(sfd[0]),
    .prog_fetch_done(pfd[0]), .ex_busy(exb[0]), .mem_busy(memb[0]), .halt(hlt[0]),
    .tx_0x99(tx99[0]), .size_wren(szw[0]), .prog_wren(pgw[0]), .tx_0xAA(txaa[0]),
    .core_reset(crst[0]), .wb_if_wren(wbif[0]), .if_id_wren(ifid[0]),
    .id_ex_wren(idex[0]), .ex_mem_wren(exmem[0]), .mem_wb_wren(memwb[0]),
    .ram_wren(ram[0]), .reg_wren(regw[0]), .state(st[0]), .halted(hltd[0]),
    .instr_count(cnt_a));

  stage_sequencer #(.BOOT_EN(1'b0), .MEM_LATENCY(1), .CNT_W(32)) dut_b (
    .clk(clk), .reset(rst[1]), .stall(stl[1]), .size_fetch_done(sfd[1]),
    .prog_fetch_done(pfd[1]), .ex_busy(exb[1]), .mem_busy(memb[1]), .halt(hlt[1]),
    .tx_0x99(tx99[1]), .size_wren(szw[1]), .prog_wren(pgw[1]), .tx_0xAA(txaa[1]),
    .core_reset(crst[1]), .wb_if_wren(wbif[1]), .if_id_wren(ifid[1]),
    .id_ex_wren(idex[1]), .ex_mem_wren(exmem[1]), .mem_wb_wren(memwb[1]),
    .ram_wren(ram[1]), .reg_wren(regw[1]), .state(st[1]), .halted(hltd[1]),
    .instr_count(cnt_b));

  localparam logic [12:0] M_TX = 13'h1000, M_SZ = 13'h0800, M_PG = 13'h0400;
  localparam logic [12:0] M_AA = 13'h0200, M_CR = 13'h0100, M_WBIF = 13'h0080;
  localparam logic [12:0] M_IFID = 13'h0040, M_IDEX = 13'h0020, M_EXMEM = 13'h0010;
  localparam logic [12:0] M_MEMWB = 13'h0008, M_RAM = 13'h0004, M_REG = 13'h0002;
  localparam logic [12:0] M_HLT = 13'h0001;

  // Strobes each state owns, indexed by state code.
  localparam logic [12:0] TAB [16] = '{
    M_TX | M_CR, M_SZ | M_CR, M_PG | M_CR, M_AA | M_CR, M_CR,
    13'h0, M_IFID, 13'h0, M_IDEX, 13'h0, M_EXMEM, 13'h0,
    M_MEMWB, M_REG, M_WBIF, M_HLT};

  localparam int P_BOOT [2] = '{1, 0};
  localparam int P_LAT  [2] = '{3, 1};
  localparam int P_W    [2] = '{4, 32};

  int          checks = 0;
  int          failures = 0;
  int          m_st [2], m_memn [2], ret [2];
  longint      m_cnt [2];
  logic [12:0] snap_vec [2];
  int          snap_st [2];
  longint      snap_cnt [2];

  function automatic logic [12:0] obs(int id);
    return {tx99[id], szw[id], pgw[id], txaa[id], crst[id], wbif[id], ifid[id],
            idex[id], exmem[id], memwb[id], ram[id], regw[id], hltd[id]};
  endfunction

  function automatic longint obs_cnt(int id);
    return (id == 0) ? longint'(cnt_a) : longint'(cnt_b);
  endfunction

  function automatic logic [12:0] expv(int id);
    logic [12:0] e;
    e = TAB[m_st[id]];
    if (m_st[id] == 11 && m_memn[id] == 0) e = e | M_RAM;
    if (stl[id]) e = e & (M_CR | M_HLT);
    return e;
  endfunction

  task automatic model_update(int id);
    int s;
    s = m_st[id];
    if (rst[id]) begin
      m_st[id] = (P_BOOT[id] != 0) ? 0 : 4;
      m_memn[id] = 0; m_cnt[id] = 0; ret[id] = 0;
    end else if (!stl[id]) begin
      case (s)
        1:  if (sfd[id]) m_st[id] = 2;
        2:  if (pfd[id]) m_st[id] = 3;
        9:  if (!exb[id]) m_st[id] = 10;
        11: begin
          if (m_memn[id] >= P_LAT[id] - 1 && !memb[id]) m_st[id] = 12;
          m_memn[id]++;
        end
        14: begin
          m_cnt[id] = (m_cnt[id] + 1) & ((longint'(1) << P_W[id]) - 1);
          ret[id]++;
          m_st[id] = hlt[id] ? 15 : 5;
        end
        15: m_st[id] = 15;
        default: m_st[id] = s + 1;
      endcase
      if (m_st[id] == 11 && s != 11) m_memn[id] = 0;
    end
  endtask

  task automatic chk(string tag, longint o, longint e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clock: compare both DUTs against the model, then advance the model.
  task automatic step();
    #1;
    for (int id = 0; id < 2; id++) begin
      snap_vec[id] = obs(id);
      snap_st[id]  = int'(st[id]);
      snap_cnt[id] = obs_cnt(id);
      checks++;
      assert (snap_vec[id] === expv(id)) else begin
        failures++;
        $error("FAIL strobes_%0d observed=%b expected=%b", id, snap_vec[id], expv(id));
      end
      chk($sformatf("state_%0d", id), snap_st[id], m_st[id]);
      chk($sformatf("instr_count_%0d", id), snap_cnt[id], m_cnt[id]);
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic run_until(int id, int target, int bound);
    int n;
    n = 0;
    while (m_st[id] != target && n < bound) begin
      step();
      n++;
    end
    chk("run_until_timeout", m_st[id], target);
  endtask

  initial begin
    logic [13:0] bt_tx, bt_sz, bt_pg, bt_aa, bt_cr, bt_init, bt_if;
    int ex_n, mem_n, ram_n, loop_n, stall_n, wb_n, wb_first, wb_last, ifid_n, reg_n;

    for (int id = 0; id < 2; id++) begin
      rst[id] = 1'b1; stl[id] = 1'b0; sfd[id] = 1'b0; pfd[id] = 1'b0;
      exb[id] = 1'b0; memb[id] = 1'b0; hlt[id] = 1'b0;
      m_st[id] = 0; m_memn[id] = 0; m_cnt[id] = 0; ret[id] = 0;
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);

    // Reset state
    step();
    chk("reset_state_a", snap_st[0], 0);
    chk("reset_state_b", snap_st[1], 4);
    chk("reset_strobes_a", snap_vec[0], M_TX | M_CR);

    // Boot timing on A
    rst[0] = 1'b0;
    bt_tx = '0; bt_sz = '0; bt_pg = '0; bt_aa = '0; bt_cr = '0; bt_init = '0; bt_if = '0;
    for (int c = 0; c < 14; c++) begin
      sfd[0] = (c >= 3);
      pfd[0] = (c >= 10);
      step();
      bt_tx[c] = snap_vec[0][12];
      bt_sz[c] = snap_vec[0][11];
      bt_pg[c] = snap_vec[0][10];
      bt_aa[c] = snap_vec[0][9];
      bt_cr[c] = snap_vec[0][8];
      bt_init[c] = (snap_st[0] == 4);
      bt_if[c] = (snap_st[0] == 5);
    end
    chk("boot_tx99", bt_tx, 14'h0001);
    chk("boot_size_wren", bt_sz, 14'h000E);
    chk("boot_prog_wren", bt_pg, 14'h07F0);
    chk("boot_tx_aa", bt_aa, 14'h0800);
    chk("boot_core_reset", bt_cr, 14'h1FFF);
    chk("boot_init_cycle", bt_init, 14'h1000);
    chk("boot_if_cycle", bt_if, 14'h2000);

    // EX/MEM dwell on A: ex_busy 4 cycles, mem_busy 5 cycles from entry
    run_until(0, 5, 40);
    ex_n = 0; mem_n = 0; ram_n = 0; loop_n = 0;
    do begin
      exb[0]  = (m_st[0] == 9 && ex_n < 4);
      memb[0] = (m_st[0] == 11 && mem_n < 5);
      step();
      loop_n++;
      if (snap_st[0] == 9) ex_n++;
      if (snap_st[0] == 11) mem_n++;
      ram_n += int'(snap_vec[0][2]);
    end while (snap_st[0] != 14 && loop_n < 100);
    exb[0] = 1'b0; memb[0] = 1'b0;
    chk("dwell_ex_cycles", ex_n, 5);
    chk("dwell_mem_cycles", mem_n, 6);
    chk("dwell_ram_pulses", ram_n, 1);
    // 8 single-cycle states + EX 5 + MEM 6
    chk("dwell_loop_cycles", loop_n, 19);

    // Stall for 7 cycles from the second MEM cycle on A
    run_until(0, 5, 10);
    mem_n = 0; ram_n = 0; loop_n = 0; stall_n = 0;
    do begin
      stl[0] = (m_st[0] == 11 && mem_n >= 1 && stall_n < 7);
      step();
      loop_n++;
      if (stl[0]) begin
        stall_n++;
        chk("stall_state_hold", snap_st[0], 11);
        chk("stall_quiet", snap_vec[0] & ~(M_CR | M_HLT), 0);
      end
      if (snap_st[0] == 11) mem_n++;
      ram_n += int'(snap_vec[0][2]);
    end while (snap_st[0] != 14 && loop_n < 100);
    stl[0] = 1'b0;
    chk("stall_cycles", stall_n, 7);
    chk("stall_mem_dwell", mem_n, 3 + 7);
    chk("stall_ram_pulses", ram_n, 1);

    // Halt in WB_IF of the 17th instruction, count wraps 15 -> 0 -> 1
    loop_n = 0;
    while (!(m_st[0] == 14 && ret[0] == 16) && loop_n < 2000) begin
      exb[0]  = ($urandom_range(0, 3) == 0);
      memb[0] = ($urandom_range(0, 3) == 0);
      step();
      loop_n++;
    end
    exb[0] = 1'b0; memb[0] = 1'b0;
    chk("halt_reach_timeout", ret[0], 16);
    hlt[0] = 1'b1;
    step();
    chk("halt_wb_if_wren", snap_vec[0][7], 1);
    hlt[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stl[0] = 1'(($urandom_range(0, 2)) == 0);
      exb[0] = 1'($urandom_range(0, 1));
      sfd[0] = 1'($urandom_range(0, 1));
      hlt[0] = 1'($urandom_range(0, 1));
      step();
      chk("halt_state", snap_st[0], 15);
      chk("halt_halted", snap_vec[0][0], 1);
      chk("halt_wrapped_count", snap_cnt[0], 1);
    end
    stl[0] = 1'b0; exb[0] = 1'b0; hlt[0] = 1'b0;

    // Reset from PROG on A
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    sfd[0] = 1'b1; pfd[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    chk("prog_before_reset", snap_st[0], 2);
    step();
    chk("prog_reset_state", snap_st[0], 0);
    chk("prog_reset_strobes", snap_vec[0], M_TX | M_CR);
    chk("prog_reset_count", snap_cnt[0], 0);

    // Reset from MEM on A
    pfd[0] = 1'b1;
    run_until(0, 11, 30);
    step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    chk("mem_before_reset_a", snap_st[0], 11);
    step();
    chk("mem_reset_state_a", snap_st[0], 0);
    chk("mem_reset_strobes_a", snap_vec[0], M_TX | M_CR);
    rst[0] = 1'b1;

    // Nominal loop on B: 5 instructions, no dwell
    rst[1] = 1'b0;
    wb_n = 0; wb_first = -1; wb_last = -1; ram_n = 0; ifid_n = 0; reg_n = 0;
    for (int c = 0; c < 52; c++) begin
      step();
      if (snap_vec[1][7]) begin
        wb_n++;
        if (wb_first < 0) wb_first = c;
        wb_last = c;
      end
      ram_n  += int'(snap_vec[1][2]);
      ifid_n += int'(snap_vec[1][6]);
      reg_n  += int'(snap_vec[1][1]);
    end
    chk("nominal_wb_if_pulses", wb_n, 5);
    chk("nominal_first_wb_if", wb_first, 10);
    chk("nominal_last_wb_if", wb_last, 50);
    chk("nominal_ram_pulses", ram_n, 5);
    chk("nominal_if_id_pulses", ifid_n, 5);
    chk("nominal_reg_pulses", reg_n, 5);
    chk("nominal_instr_count", snap_cnt[1], 5);

    // Reset from MEM on B
    run_until(1, 11, 20);
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    chk("mem_before_reset_b", snap_st[1], 11);
    step();
    chk("mem_reset_state_b", snap_st[1], 4);
    chk("mem_reset_strobes_b", snap_vec[1], M_CR);
    chk("mem_reset_count_b", snap_cnt[1], 0);

    // Randomised traffic on both instances against the model
    for (int i = 0; i < 3000; i++) begin
      for (int id = 0; id < 2; id++) begin
        rst[id]  = ($urandom_range(0, 99) == 0);
        stl[id]  = ($urandom_range(0, 7) == 0);
        sfd[id]  = ($urandom_range(0, 3) == 0);
        pfd[id]  = ($urandom_range(0, 3) == 0);
        exb[id]  = ($urandom_range(0, 2) == 0);
        memb[id] = ($urandom_range(0, 2) == 0);
        hlt[id]  = ($urandom_range(0, 15) == 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
